// File: rtl/mem_port_arb_if.sv
// Bundle of the load, store-commit, memory and response signals around the memory port arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline and memory.
interface mem_port_arb_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;

  logic              ld_req_valid;
  logic [ADDR_W-1:0] ld_req_addr;
  logic              ld_req_ready;
  logic              st_req_valid;
  logic [ADDR_W-1:0] st_req_addr;
  logic [DATA_W-1:0] st_req_data;
  logic              st_urgent;
  logic              st_req_ready;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic              ld_resp_valid;
  logic [DATA_W-1:0] ld_resp_data;
  logic              st_ack;
  logic              flush;
  logic [CNT_W-1:0]  outstanding;
  logic              protocol_err;

  modport slave (
    input  ld_req_valid, ld_req_addr, st_req_valid, st_req_addr, st_req_data, st_urgent,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, flush,
    output ld_req_ready, st_req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output ld_resp_valid, ld_resp_data, st_ack, outstanding, protocol_err
  );

  modport master (
    output ld_req_valid, ld_req_addr, st_req_valid, st_req_addr, st_req_data, st_urgent,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, flush,
    input  ld_req_ready, st_req_ready, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  ld_resp_valid, ld_resp_data, st_ack, outstanding, protocol_err
  );
endinterface

// File: rtl/mem_port_arb.sv
// Shares one in-order memory port between loads and committed stores, routing responses back by tag FIFO.
// Request and response paths are combinational (zero latency); issue stalls on mem_req_ready or MAX_OUT in flight.
module mem_port_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_port_arb_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_OUT) + 1;
  localparam int PTR_W = $clog2(MAX_OUT);

  typedef enum logic {GNT_LD = 1'b0, GNT_ST = 1'b1} gnt_e;

  gnt_e               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [MAX_OUT-1:0] is_load_q, is_load_d;
  logic [MAX_OUT-1:0] discard_q, discard_d;
  logic               perr_q, perr_d;

  logic              ld_elig, st_elig;
  logic              grant_ld, grant_st;
  logic              can_issue, fire;
  logic              fifo_empty, pop;
  logic              head_load, head_drop;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  // Loads are held off during flush so nothing pushed that cycle needs squashing.
  assign ld_elig  = bus.ld_req_valid && !bus.flush;
  assign st_elig  = bus.st_req_valid;
  assign grant_st = st_elig && (!ld_elig || bus.st_urgent || (last_grant_q == GNT_LD));
  assign grant_ld = ld_elig && !grant_st;

  // Registered count only: a pop in the full cycle frees a slot for the next cycle.
  assign can_issue = (cnt_q < CNT_W'(MAX_OUT));
  assign fire      = bus.mem_req_valid && bus.mem_req_ready;

  assign req_addr  = grant_st ? bus.st_req_addr : bus.ld_req_addr;
  assign req_wdata = grant_st ? bus.st_req_data : '0;

  assign bus.mem_req_valid = (grant_ld || grant_st) && can_issue;
  assign bus.mem_req_we    = grant_st;
  assign bus.mem_req_addr  = req_addr;
  assign bus.mem_req_wdata = req_wdata;
  assign bus.ld_req_ready  = fire && grant_ld;
  assign bus.st_req_ready  = fire && grant_st;

  assign fifo_empty = (cnt_q == '0);
  assign pop        = bus.mem_rsp_valid && !fifo_empty;
  assign head_load  = is_load_q[rd_ptr_q];
  assign head_drop  = discard_q[rd_ptr_q] || bus.flush;

  assign bus.ld_resp_valid = pop && head_load && !head_drop;
  assign bus.ld_resp_data  = bus.mem_rsp_data;
  assign bus.st_ack        = pop && !head_load;
  assign bus.outstanding   = cnt_q;
  assign bus.protocol_err  = perr_q;

  always_comb begin
    is_load_d    = is_load_q;
    discard_d    = discard_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    perr_d       = perr_q || (bus.mem_rsp_valid && fifo_empty);

    if (bus.flush) begin
      discard_d = discard_q | is_load_q;
    end
    if (fire) begin
      is_load_d[wr_ptr_q] = grant_ld;
      discard_d[wr_ptr_q] = 1'b0;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      last_grant_d        = grant_st ? GNT_ST : GNT_LD;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({fire, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GNT_LD;
      cnt_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      is_load_q    <= '0;
      discard_q    <= '0;
      perr_q       <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      is_load_q    <= is_load_d;
      discard_q    <= discard_d;
      perr_q       <= perr_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arb.sv
// Scenario bench for mem_port_arb: the bench plays both requesters and the memory.
// A negedge monitor scores every memory request, load response and store ack against queued expectations.
module tb_mem_port_arb;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MAX_OUT = 4;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  req_t              exp_req_q[$];
  logic [DATA_W-1:0] exp_ld_q[$];
  int                exp_ack_n;

  mem_port_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) bus ();

  mem_port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard monitor: every observed transfer must match the head of its expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        req_t got;
        req_t e;
        got = '{we: bus.mem_req_we, addr: bus.mem_req_addr, wdata: bus.mem_req_wdata};
        checks++;
        if (exp_req_q.size() == 0) begin
          errors++;
          $display("FAIL mem_req_unexpected: got we=%0b addr=%h wdata=%h, required no request", got.we, got.addr, got.wdata);
        end else begin
          e = exp_req_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL mem_req: got we=%0b addr=%h wdata=%h, required we=%0b addr=%h wdata=%h", got.we, got.addr, got.wdata, e.we, e.addr, e.wdata);
          end
        end
      end
      if (bus.ld_resp_valid) begin
        logic [DATA_W-1:0] ed;
        checks++;
        if (exp_ld_q.size() == 0) begin
          errors++;
          $display("FAIL ld_resp_unexpected: got data=%h, required no load response", bus.ld_resp_data);
        end else begin
          ed = exp_ld_q.pop_front();
          if (bus.ld_resp_data !== ed) begin
            errors++;
            $display("FAIL ld_resp_data: got %h, required %h", bus.ld_resp_data, ed);
          end
        end
      end
      if (bus.st_ack) begin
        checks++;
        if (exp_ack_n == 0) begin
          errors++;
          $display("FAIL st_ack_unexpected: got st_ack=1, required 0");
        end else begin
          exp_ack_n--;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.ld_req_valid  = 1'b0;
    bus.ld_req_addr   = '0;
    bus.st_req_valid  = 1'b0;
    bus.st_req_addr   = '0;
    bus.st_req_data   = '0;
    bus.st_urgent     = 1'b0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    bus.flush         = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Drives one memory response and records what the arbiter should return for it.
  task automatic respond(input logic is_ld, input logic [DATA_W-1:0] d);
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = d;
    if (is_ld) exp_ld_q.push_back(d);
    else exp_ack_n++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.outstanding !== '0) begin
      errors++; $display("FAIL reset_outstanding: got %0d, required 0", bus.outstanding);
    end
    checks++;
    if (bus.protocol_err !== 1'b0) begin
      errors++; $display("FAIL reset_protocol_err: got %0b, required 0", bus.protocol_err);
    end
    checks++;
    if ({bus.mem_req_valid, bus.ld_req_ready, bus.st_req_ready, bus.ld_resp_valid, bus.st_ack} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b ldrdy=%0b strdy=%0b ldresp=%0b ack=%0b, required all 0",
               bus.mem_req_valid, bus.ld_req_ready, bus.st_req_ready, bus.ld_resp_valid, bus.st_ack);
    end
  endtask

  task automatic test_single_load();
    tick();
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h100;
    exp_req_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    @(negedge clk);
    checks++;
    if (bus.ld_req_ready !== 1'b1) begin
      errors++; $display("FAIL single_ld_ready: got %0b, required 1", bus.ld_req_ready);
    end
    tick();
    bus.ld_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outstanding !== 3'd1) begin
      errors++; $display("FAIL single_outstanding_1: got %0d, required 1", bus.outstanding);
    end
    respond(1'b1, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (bus.ld_resp_valid !== 1'b1) begin
      errors++; $display("FAIL single_ld_resp_valid: got %0b, required 1", bus.ld_resp_valid);
    end
    tick();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outstanding !== 3'd0 || bus.ld_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got outstanding=%0d ldresp=%0b, required 0 and 0", bus.outstanding, bus.ld_resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic exp_st;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.ld_req_valid = 1'b1;
      bus.ld_req_addr  = 32'h200;
      bus.st_req_valid = 1'b1;
      bus.st_req_addr  = 32'h300;
      bus.st_req_data  = 32'h55;
      bus.st_urgent    = 1'b0;
      exp_st = (i % 2 == 0);
      if (exp_st) exp_req_q.push_back('{we: 1'b1, addr: 32'h300, wdata: 32'h55});
      else exp_req_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
      @(negedge clk);
      checks++;
      if (bus.st_req_ready !== exp_st || bus.ld_req_ready !== !exp_st) begin
        errors++;
        $display("FAIL rr_grant_%0d: got strdy=%0b ldrdy=%0b, required strdy=%0b ldrdy=%0b", i, bus.st_req_ready, bus.ld_req_ready, exp_st, !exp_st);
      end
    end
    tick();
    idle_inputs();
    respond(1'b0, 32'h0);
    respond(1'b1, 32'h1111_0001);
    respond(1'b0, 32'h0);
    respond(1'b1, 32'h1111_0002);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.mem_rsp_valid = 1'b0;
      bus.ld_req_valid  = 1'b1;
      bus.ld_req_addr   = 32'h240;
      bus.st_req_valid  = 1'b1;
      bus.st_req_addr   = 32'h340;
      bus.st_req_data   = 32'h66;
      bus.st_urgent     = 1'b1;
      exp_req_q.push_back('{we: 1'b1, addr: 32'h340, wdata: 32'h66});
      @(negedge clk);
      checks++;
      if (bus.st_req_ready !== 1'b1) begin
        errors++; $display("FAIL urgent_grant_%0d: got strdy=%0b, required 1", i, bus.st_req_ready);
      end
    end
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) respond(1'b0, 32'h0);
    tick();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.ld_req_valid = 1'b1;
      bus.ld_req_addr  = 32'h400 + 32'(4 * i);
      exp_req_q.push_back('{we: 1'b0, addr: 32'h400 + 32'(4 * i), wdata: 32'h0});
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      bus.ld_req_addr = 32'h500;
      @(negedge clk);
      checks++;
      if (bus.mem_req_valid !== 1'b0 || bus.outstanding !== 3'd4) begin
        errors++;
        $display("FAIL full_stall_%0d: got valid=%0b outstanding=%0d, required 0 and 4", i, bus.mem_req_valid, bus.outstanding);
      end
    end
    respond(1'b1, 32'hA0);
    @(negedge clk);
    checks++;
    if (bus.mem_req_valid !== 1'b0) begin
      errors++; $display("FAIL full_pop_same_cycle: got valid=%0b, required 0", bus.mem_req_valid);
    end
    tick();
    bus.mem_rsp_valid = 1'b0;
    exp_req_q.push_back('{we: 1'b0, addr: 32'h500, wdata: 32'h0});
    @(negedge clk);
    checks++;
    if (bus.mem_req_valid !== 1'b1 || bus.ld_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_next_issue: got valid=%0b ldrdy=%0b, required 1 and 1", bus.mem_req_valid, bus.ld_req_ready);
    end
    tick();
    bus.ld_req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) respond(1'b1, 32'hA0 + 32'(i));
    tick();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outstanding !== 3'd0) begin
      errors++; $display("FAIL full_drained: got outstanding=%0d, required 0", bus.outstanding);
    end
  endtask

  task automatic test_flush();
    tick();
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h600;
    exp_req_q.push_back('{we: 1'b0, addr: 32'h600, wdata: 32'h0});
    tick();
    bus.ld_req_valid = 1'b0;
    bus.st_req_valid = 1'b1;
    bus.st_req_addr  = 32'h700;
    bus.st_req_data  = 32'h77;
    exp_req_q.push_back('{we: 1'b1, addr: 32'h700, wdata: 32'h77});
    tick();
    bus.st_req_valid = 1'b0;
    bus.ld_req_valid = 1'b1;
    bus.ld_req_addr  = 32'h800;
    exp_req_q.push_back('{we: 1'b0, addr: 32'h800, wdata: 32'h0});
    tick();
    bus.flush       = 1'b1;
    bus.ld_req_addr = 32'h900;
    @(negedge clk);
    checks++;
    if (bus.mem_req_valid !== 1'b0 || bus.ld_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_blocks_load: got valid=%0b ldrdy=%0b, required 0 and 0", bus.mem_req_valid, bus.ld_req_ready);
    end
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = 32'hF00 + 32'(i);
      if (i == 1) exp_ack_n++;
      @(negedge clk);
      checks++;
      if (bus.ld_resp_valid !== 1'b0 || bus.st_ack !== (i == 1)) begin
        errors++;
        $display("FAIL flush_rsp_%0d: got ldresp=%0b ack=%0b, required ldresp=0 ack=%0b", i, bus.ld_resp_valid, bus.st_ack, (i == 1));
      end
    end
    tick();
    bus.mem_rsp_valid = 1'b0;
    bus.ld_req_valid  = 1'b1;
    bus.ld_req_addr   = 32'hA00;
    exp_req_q.push_back('{we: 1'b0, addr: 32'hA00, wdata: 32'h0});
    @(negedge clk);
    checks++;
    if (bus.outstanding !== 3'd0) begin
      errors++; $display("FAIL flush_drained: got outstanding=%0d, required 0", bus.outstanding);
    end
    tick();
    bus.ld_req_valid  = 1'b0;
    bus.flush         = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'hBAD;
    bus.st_req_valid  = 1'b1;
    bus.st_req_addr   = 32'hB00;
    bus.st_req_data   = 32'hBB;
    exp_req_q.push_back('{we: 1'b1, addr: 32'hB00, wdata: 32'hBB});
    @(negedge clk);
    checks++;
    if (bus.ld_resp_valid !== 1'b0 || bus.st_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_same_cycle: got ldresp=%0b strdy=%0b, required 0 and 1", bus.ld_resp_valid, bus.st_req_ready);
    end
    tick();
    idle_inputs();
    respond(1'b0, 32'h0);
    @(negedge clk);
    checks++;
    if (bus.st_ack !== 1'b1) begin
      errors++; $display("FAIL flush_store_ack: got %0b, required 1", bus.st_ack);
    end
    tick();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.outstanding !== 3'd0) begin
      errors++; $display("FAIL flush_final_count: got outstanding=%0d, required 0", bus.outstanding);
    end
  endtask

  task automatic test_protocol_err();
    tick();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data  = 32'h1234;
    @(negedge clk);
    checks++;
    if (bus.ld_resp_valid !== 1'b0 || bus.st_ack !== 1'b0) begin
      errors++;
      $display("FAIL perr_no_resp: got ldresp=%0b ack=%0b, required 0 and 0", bus.ld_resp_valid, bus.st_ack);
    end
    tick();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.protocol_err !== 1'b1) begin
      errors++; $display("FAIL perr_set: got %0b, required 1", bus.protocol_err);
    end
    for (int i = 0; i < 3; i++) tick();
    @(negedge clk);
    checks++;
    if (bus.protocol_err !== 1'b1 || bus.outstanding !== 3'd0) begin
      errors++;
      $display("FAIL perr_sticky: got perr=%0b outstanding=%0d, required 1 and 0", bus.protocol_err, bus.outstanding);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.protocol_err !== 1'b0) begin
      errors++; $display("FAIL perr_cleared: got %0b, required 0", bus.protocol_err);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.mem_req_ready = 1'b0;
      bus.ld_req_valid  = 1'b1;
      bus.ld_req_addr   = 32'hC00;
      bus.st_req_valid  = 1'b1;
      bus.st_req_addr   = 32'hD00;
      bus.st_req_data   = 32'hDD;
      @(negedge clk);
      checks++;
      if ({bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.st_req_ready, bus.ld_req_ready} !== {1'b1, 1'b1, 32'hD00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL stall_%0d: got valid=%0b we=%0b addr=%h strdy=%0b ldrdy=%0b, required 1 1 00000d00 0 0",
                 i, bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.st_req_ready, bus.ld_req_ready);
      end
    end
    tick();
    bus.mem_req_ready = 1'b1;
    exp_req_q.push_back('{we: 1'b1, addr: 32'hD00, wdata: 32'hDD});
    @(negedge clk);
    checks++;
    if (bus.st_req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_release_store: got strdy=%0b, required 1", bus.st_req_ready);
    end
    tick();
    exp_req_q.push_back('{we: 1'b0, addr: 32'hC00, wdata: 32'h0});
    @(negedge clk);
    checks++;
    if (bus.ld_req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_then_load: got ldrdy=%0b, required 1", bus.ld_req_ready);
    end
    tick();
    idle_inputs();
    respond(1'b0, 32'h0);
    respond(1'b1, 32'hCAFE);
    tick();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic test_scoreboard_empty();
    tick();
    @(negedge clk);
    checks++;
    if (exp_req_q.size() != 0 || exp_ld_q.size() != 0 || exp_ack_n != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got req=%0d ld=%0d ack=%0d pending, required 0 0 0", exp_req_q.size(), exp_ld_q.size(), exp_ack_n);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_ack_n = 0;
    rst       = 1'b1;
    idle_inputs();
    test_reset();
    test_single_load();
    test_round_robin();
    test_full();
    test_flush();
    test_protocol_err();
    test_backpressure();
    test_scoreboard_empty();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
